// File: rtl/restoring_divider_pkg.sv
// Shared constants for the chroma-path divider: default widths, state encoding
// and the saturated result returned on a zero divisor.
package restoring_divider_pkg;

    localparam int DEF_DW = 16;
    localparam int DEF_FW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [DEF_DW-1:0] SAT_QUOTIENT   = '1;
    localparam logic [DEF_FW-1:0] SAT_FRACTIONAL = '1;

endpackage

// File: rtl/restoring_divider_if.sv
// Operand/result handshake bundle between the FIFO read side and the divider.
interface restoring_divider_if
    import restoring_divider_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int FW = DEF_FW
);
    logic          in_valid;
    logic [DW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          rfd;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [FW-1:0] fractional;
    logic          div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  rfd, out_valid, quotient, fractional, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output rfd, out_valid, quotient, fractional, div_by_zero
    );
endinterface

// File: rtl/restoring_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// remainder, trial-subtract the divisor, keep the difference if it fits.
module div_step
    import restoring_divider_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic [DW:0]   rem_i,
    input  logic          bit_i,
    input  logic [DW-1:0] divisor_i,
    output logic [DW:0]   rem_o,
    output logic          q_o
);
    logic [DW+1:0] shifted;
    logic [DW:0]   diff;

    // NOTE: every output of a combinational block is assigned on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted[DW:0] - {1'b0, divisor_i};
        q_o     = (shifted >= {2'b00, divisor_i});
        rem_o   = q_o ? diff : shifted[DW:0];
    end
endmodule

// File: rtl/restoring_divider.sv
// Sequential restoring divider producing floor(dividend * 2^FW / divisor)
// as a 16.8 fixed-point result, one quotient bit per clock.
module restoring_divider
    import restoring_divider_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    restoring_divider_if.slave bus
);
    localparam int DW = DEF_DW;
    localparam int FW = DEF_FW;
    localparam int RW = DW + FW;
    localparam int CW = $clog2(RW);

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW:0]   rem_q,   rem_d;
    logic [RW-1:0] dvd_q,   dvd_d;
    logic [DW-1:0] dvs_q,   dvs_d;
    logic [RW-1:0] res_q,   res_d;
    logic          dbz_q,   dbz_d;

    logic [DW:0]   step_rem;
    logic          step_q;

    div_step #(.DW(DW)) u_div_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[RW-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    dvs_d   = bus.divisor;
                    dvd_d   = {bus.dividend, {FW{1'b0}}};
                    rem_d   = '0;
                    res_d   = '0;
                    dbz_d   = 1'b0;
                    count_d = CW'(RW - 1);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                // A zero divisor spends exactly one CALC cycle, so its
                // result appears one clock after the accept edge.
                if (dvs_q == '0) begin
                    res_d   = {SAT_QUOTIENT, SAT_FRACTIONAL};
                    dbz_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    rem_d   = step_rem;
                    res_d   = {res_q[RW-2:0], step_q};
                    dvd_d   = dvd_q << 1;
                    count_d = count_q - 1'b1;
                    if (count_q == '0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.rfd         = (state_q == ST_IDLE);
    assign bus.out_valid   = (state_q == ST_DONE);
    assign bus.quotient    = res_q[RW-1:FW];
    assign bus.fractional  = res_q[FW-1:0];
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider: hand-computed results,
// latency, throughput, backpressure, divide-by-zero and mid-operation reset.
module tb_restoring_divider;
    import restoring_divider_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   n_fail;

    restoring_divider_if bus ();

    restoring_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        check("rfd_before_accept", 32'(bus.rfd), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("rfd_after_accept", 32'(bus.rfd), 32'd0);
    endtask

    // Returns the number of edges after the accept edge until out_valid.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic pop();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("rfd_after_pop", 32'(bus.rfd), 32'd1);
        check("valid_after_pop", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic run_div(input logic [15:0] a, input logic [15:0] b, input int exp_lat,
                           input logic [15:0] exp_q, input logic [7:0] exp_f, input logic exp_z);
        int cyc;
        start(a, b);
        wait_done(cyc);
        check("latency", 32'(cyc), 32'(exp_lat));
        check("quotient", 32'(bus.quotient), 32'(exp_q));
        check("fractional", 32'(bus.fractional), 32'(exp_f));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(exp_z));
        pop();
    endtask

    initial begin
        int  n;
        int  cyc;
        bit  seen;
        bit  bad;

        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("reset_rfd", 32'(bus.rfd), 32'd1);
        check("reset_valid", 32'(bus.out_valid), 32'd0);
        check("reset_quotient", 32'(bus.quotient), 32'd0);
        check("reset_fractional", 32'(bus.fractional), 32'd0);
        check("reset_dbz", 32'(bus.div_by_zero), 32'd0);

        // 25600/109 = 234.86, 256000/3 = 85333 = 333*256+85, 7*256/2 = 896 = 3*256+128
        run_div(16'd100,    16'd109, 24, 16'd0,      8'd234, 1'b0);
        run_div(16'd1000,   16'd3,   24, 16'd333,    8'd85,  1'b0);
        run_div(16'd47,     16'd47,  24, 16'd1,      8'd0,   1'b0);
        run_div(16'd0,      16'd5,   24, 16'd0,      8'd0,   1'b0);
        run_div(16'd7,      16'd2,   24, 16'd3,      8'd128, 1'b0);
        run_div(16'd5,      16'd0,   1,  16'hFFFF,   8'hFF,  1'b1);
        run_div(16'hFFFF,   16'd1,   24, 16'hFFFF,   8'd0,   1'b0);

        // Back-to-back with out_ready held: accepts 26 clocks apart
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.dividend  = 16'hFFFF;
        bus.divisor   = 16'd1;
        check("b2b_rfd_start", 32'(bus.rfd), 32'd1);
        n    = 0;
        seen = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (bus.out_valid && !seen) begin
                seen = 1'b1;
                check("b2b_quotient", 32'(bus.quotient), 32'hFFFF);
                check("b2b_fractional", 32'(bus.fractional), 32'd0);
            end
        end while (!bus.rfd && n < 64);
        check("b2b_result_seen", 32'(seen), 32'd1);
        check("b2b_spacing", 32'(n), 32'd26);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.rfd && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("b2b_second_cycle", 32'(n), 32'd25);
        bus.out_ready = 1'b0;

        // Backpressure: result held, in_valid pulses ignored
        start(16'd1000, 16'd3);
        wait_done(cyc);
        check("bp_latency", 32'(cyc), 32'd24);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = i[0];
            bus.dividend = 16'd7;
            bus.divisor  = 16'd2;
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_rfd", 32'(bus.rfd), 32'd0);
            check("bp_quotient", 32'(bus.quotient), 32'd333);
            check("bp_fractional", 32'(bus.fractional), 32'd85);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        pop();
        bad = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid || !bus.rfd) bad = 1'b1;
        end
        check("bp_no_queue", 32'(bad), 32'd0);

        // Reset on the 10th CALC iteration edge aborts the operation
        start(16'd1000, 16'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_rfd", 32'(bus.rfd), 32'd1);
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_quotient", 32'(bus.quotient), 32'd0);
        check("abort_fractional", 32'(bus.fractional), 32'd0);
        check("abort_dbz", 32'(bus.div_by_zero), 32'd0);
        bad = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) bad = 1'b1;
        end
        check("abort_no_result", 32'(bad), 32'd0);
        run_div(16'd1000, 16'd3, 24, 16'd333, 8'd85, 1'b0);

        // Simultaneous rst and in_valid: operands dropped
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.dividend = 16'd5;
        bus.divisor  = 16'd0;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_win_rfd", 32'(bus.rfd), 32'd1);
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid) bad = 1'b1;
        end
        check("rst_win_no_result", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
